// File: rtl/divider_nr.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock,
// BITS CALC steps plus one FIX step, result presented with a one-cycle done pulse.
module divider_nr #(
   parameter int BITS = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] dividend,
   input  logic [BITS-1:0] divisor,
   output logic            done,
   output logic [BITS-1:0] quotient,
   output logic [BITS-1:0] remainder
);

   localparam int CW = $clog2(BITS);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state;
   logic [BITS:0]   a;        // signed partial remainder, bit BITS is the sign
   logic [BITS-1:0] q;
   logic [BITS-1:0] d;
   logic [CW-1:0]   cnt;

   logic [BITS:0]   d_ext;
   logic [BITS:0]   a_shift;
   logic [BITS:0]   a_step;
   logic [BITS-1:0] rem_fix;

   // Intermediate shifted values may wrap past the sign bit; arithmetic is
   // modulo 2^(BITS+1) and the post-step value always lands back in [-D, D).
   always_comb begin
      d_ext   = {1'b0, d};
      a_shift = {a[BITS-1:0], q[BITS-1]};
      a_step  = a[BITS] ? (a_shift + d_ext) : (a_shift - d_ext);
      rem_fix = a[BITS] ? (a[BITS-1:0] + d) : a[BITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a         <= '0;
         q         <= '0;
         d         <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a     <= '0;
                  q     <= dividend;
                  d     <= divisor;
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               a   <= a_step;
               q   <= {q[BITS-2:0], ~a_step[BITS]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(BITS-1)) state <= FIX;
            end
            FIX: begin
               quotient  <= q;
               remainder <= rem_fix;
               done      <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_nr.sv
// Randomized bench for divider_nr: a cycle-level reference model of the
// start/done protocol with plain / and % arithmetic, checked every cycle.
module tb_divider_nr;

   localparam int BITS = 16;
   localparam int LAT  = BITS + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [BITS-1:0] dividend;
   logic [BITS-1:0] divisor;
   logic            done;
   logic [BITS-1:0] quotient;
   logic [BITS-1:0] remainder;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   divider_nr #(.BITS(BITS)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend),
      .divisor(divisor), .done(done), .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: busy for BITS+1 edges after an accepted start, then a
   // one-cycle done with plain division results; reset discards everything.
   logic            m_busy;
   int              m_rem;
   logic [BITS-1:0] m_a, m_b;
   logic            exp_done;
   logic [BITS-1:0] exp_q, exp_r;

   always @(posedge clk) begin
      if (reset) begin
         m_busy   <= 1'b0;
         m_rem    <= 0;
         exp_done <= 1'b0;
         exp_q    <= '0;
         exp_r    <= '0;
      end else begin
         exp_done <= 1'b0;
         if (m_busy) begin
            if (m_rem == 1) begin
               m_busy   <= 1'b0;
               exp_done <= 1'b1;
               exp_q    <= (m_b == 0) ? {BITS{1'b1}} : m_a / m_b;
               exp_r    <= (m_b == 0) ? m_a : m_a % m_b;
            end
            m_rem <= m_rem - 1;
         end else if (start) begin
            m_busy <= 1'b1;
            m_rem  <= LAT;
            m_a    <= dividend;
            m_b    <= divisor;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("done", 32'(done), 32'(exp_done));
         chk("quotient", 32'(quotient), 32'(exp_q));
         chk("remainder", 32'(remainder), 32'(exp_r));
      end
   end

   // Launch a divide at a negedge and wait (bounded) for done; returns at the
   // negedge where done is high so a following call launches back-to-back.
   task automatic run(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input int poke_at, output int lat);
      int n;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = BITS'($urandom);
      divisor  = BITS'($urandom);
      n = 0;
      lat = -1;
      while (n < 4 * LAT) begin
         if (n == poke_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         dividend = BITS'($urandom);
         divisor  = BITS'($urandom);
         n++;
         if (done) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) chk("timeout", 32'(n), 32'(LAT));
   endtask

   int lat;
   int pulses;
   logic [BITS-1:0] ra, rb;

   initial begin
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_q", 32'(quotient), 32'd0);
      chk("reset_r", 32'(remainder), 32'd0);
      chk_en = 1'b1;

      run(16'd11, 16'd3, -1, lat);
      chk("lat_11_3", 32'(lat), 32'd17);
      chk("q_11_3", 32'(quotient), 32'd3);
      chk("r_11_3", 32'(remainder), 32'd2);
      @(negedge clk);
      chk("done_low_after", 32'(done), 32'd0);

      run(16'hFFFF, 16'd1, -1, lat);
      chk("q_ffff_1", 32'(quotient), 32'hFFFF);
      chk("r_ffff_1", 32'(remainder), 32'h0);
      run(16'd5, 16'd7, -1, lat);
      chk("q_5_7", 32'(quotient), 32'd0);
      chk("r_5_7", 32'(remainder), 32'd5);
      run(16'h8000, 16'hFFFF, -1, lat);
      chk("q_8000_ffff", 32'(quotient), 32'd0);
      chk("r_8000_ffff", 32'(remainder), 32'h8000);
      run(16'd0, 16'd0, -1, lat);
      chk("lat_0_0", 32'(lat), 32'd17);
      chk("q_0_0", 32'(quotient), 32'hFFFF);
      chk("r_0_0", 32'(remainder), 32'h0);
      run(16'h1234, 16'd0, -1, lat);
      chk("q_1234_0", 32'(quotient), 32'hFFFF);
      chk("r_1234_0", 32'(remainder), 32'h1234);

      // Start pulses mid-computation must be ignored (model + done checks).
      run(16'd1000, 16'd7, 5, lat);
      chk("lat_poke", 32'(lat), 32'd17);
      chk("q_poke", 32'(quotient), 32'd142);
      chk("r_poke", 32'(remainder), 32'd6);
      pulses = 0;
      repeat (2 * LAT) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("no_extra_done", 32'(pulses), 32'd0);

      // Reset in the middle of CALC discards the divide.
      dividend = 16'd500; divisor = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_q", 32'(quotient), 32'd0);
      chk("rst_mid_r", 32'(remainder), 32'd0);
      pulses = 0;
      repeat (2 * LAT) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("rst_mid_no_done", 32'(pulses), 32'd0);
      run(16'd11, 16'd3, -1, lat);
      chk("lat_after_rst", 32'(lat), 32'd17);
      chk("q_after_rst", 32'(quotient), 32'd3);
      chk("r_after_rst", 32'(remainder), 32'd2);

      // Random pairs, launched back-to-back in the done cycle.
      for (int i = 0; i < 120; i++) begin
         ra = BITS'($urandom);
         case ($urandom_range(0, 3))
            0: rb = BITS'($urandom);
            1: rb = BITS'($urandom_range(1, 15));
            2: rb = ($urandom_range(0, 7) == 0) ? '0 : BITS'($urandom_range(1, 255));
            default: begin rb = BITS'($urandom); ra = ra >> $urandom_range(0, 15); end
         endcase
         run(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : -1, lat);
         chk("rand_lat", 32'(lat), 32'd17);
         if (rb != 0) begin
            chk("rand_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            chk("rand_rem_lt", 32'(remainder < rb), 32'd1);
         end else begin
            chk("rand_div0_q", 32'(quotient), 32'hFFFF);
            chk("rand_div0_r", 32'(remainder), 32'(ra));
         end
      end
      @(negedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
